// File: rtl/instr_encoder.sv
// Encodes RV32-style instruction requests into 32-bit words and streams them
// into an instruction memory write port, one word per accepted request.
module instr_encoder #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op_class,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [11:0]              imm,
   input  logic                     flush,
   output logic                     imem_we,
   output logic [31:0]              imem_addr,
   output logic [31:0]              imem_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic          we_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic [CW-1:0] count_reg;
   logic          err_reg;

   logic [31:0]   word_next;
   logic          legal_next;
   logic          accept;

   assign in_ready = !rst && (count_reg < FULL) && !flush;
   assign accept   = in_valid && in_ready;

   // Branch immediate holds offset bits [12:1], so imm[k] is offset bit k+1.
   always_comb begin
      word_next  = '0;
      legal_next = 1'b1;
      case (op_class)
         3'd0: word_next = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
         3'd1: word_next = {imm, rs1, funct3, rd, 7'b0010011};
         3'd2: word_next = {imm, rs1, 3'b010, rd, 7'b0000011};
         3'd3: word_next = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
         3'd4: begin
            word_next  = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], 7'b1100011};
            legal_next = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         3'd5: word_next = {7'b0, 5'b0, rs1, 3'b000, rd, 7'b1001011};
         default: legal_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_reg    <= 1'b0;
         addr_reg  <= BASE_ADDR;
         wdata_reg <= '0;
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         we_reg <= 1'b0;
         if (flush) begin
            count_reg <= '0;
         end else if (accept) begin
            if (legal_next) begin
               we_reg    <= 1'b1;
               addr_reg  <= BASE_ADDR + (32'(count_reg) << 2);
               wdata_reg <= word_next;
               count_reg <= count_reg + 1'b1;
            end else begin
               err_reg <= 1'b1;
            end
         end
      end
   end

   assign imem_we    = we_reg;
   assign imem_addr  = addr_reg;
   assign imem_wdata = wdata_reg;
   assign count      = count_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver predicts writes into a queue,
// a monitor pops and compares each write the DUT presents.
module tb_instr_encoder;

   localparam int DEPTH = 4;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op_class = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [11:0] imm = '0;
   logic        flush = 1'b0;
   logic        imem_we;
   logic [31:0] imem_addr, imem_wdata;
   logic [$clog2(DEPTH):0] count;
   logic        err;

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_class(op_class), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .flush(flush),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int m_count = 0;
   bit m_err = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];
   int          cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference encoding built field by field from the instruction formats.
   function automatic logic [31:0] enc(input int cls, input int f3, input int f7,
                                       input int d, input int s1, input int s2, input int im);
      int o;
      o = im * 2;
      case (cls)
         0: return 32'((f7 << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + 'h33);
         1: return 32'((im << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + 'h13);
         2: return 32'((im << 20) + (s1 << 15) + (2 << 12) + (d << 7) + 'h03);
         3: return 32'(((im / 32) << 25) + (s2 << 20) + (s1 << 15) + (2 << 12)
                       + ((im % 32) << 7) + 'h23);
         4: return 32'((((o >> 12) & 1) << 31) + (((o >> 5) & 'h3F) << 25) + (s2 << 20)
                       + (s1 << 15) + (f3 << 12) + (((o >> 1) & 'hF) << 8)
                       + (((o >> 11) & 1) << 7) + 'h63);
         5: return 32'((s1 << 15) + (d << 7) + 'h4B);
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit is_legal(input int cls, input int f3);
      if (cls >= 6) return 0;
      if (cls == 4) return (f3 == 0) || (f3 == 1);
      return 1;
   endfunction

   // Present one cycle of stimulus, check in_ready, and update the model.
   task automatic step(input bit v, input int cls, input int f3, input int f7,
                       input int d, input int s1, input int s2, input int im, input bit fl);
      bit rdy;
      @(negedge clk);
      in_valid = v; op_class = 3'(cls); funct3 = 3'(f3); funct7 = 7'(f7);
      rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 12'(im); flush = fl;
      #1;
      rdy = !rst && (m_count < DEPTH) && !fl;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      if (fl) begin
         m_count = 0;
      end else if (v && rdy) begin
         if (is_legal(cls, f3)) begin
            exp_addr_q.push_back(BASE + 32'(m_count * 4));
            exp_data_q.push_back(enc(cls, f3, f7, d, s1, s2, im));
            m_count++;
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_flush();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_we", 32'(imem_we), 32'h0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
   endtask

   // Monitor: sample just after each rising edge.
   logic [31:0] prev_addr = BASE, prev_data = '0;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_cyc.push_back(cyc);
            if (exp_data_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
            end else begin
               chk("wr_addr", imem_addr, exp_addr_q.pop_front());
               chk("wr_data", imem_wdata, exp_data_q.pop_front());
            end
         end else begin
            if (exp_data_q.size() != 0) begin
               n_cmp++; n_bad++;
               $display("FAIL missing_write: got none, expected data %h", exp_data_q[0]);
               void'(exp_addr_q.pop_front());
               void'(exp_data_q.pop_front());
            end
            chk("hold_addr", imem_addr, prev_addr);
            chk("hold_data", imem_wdata, prev_data);
         end
         chk("count", 32'(count), 32'(m_count));
         chk("err", 32'(err), 32'(m_err));
      end
      prev_addr = imem_addr;
      prev_data = imem_wdata;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      int base_i;
      #3;
      check_reset_vals();
      @(negedge clk);
      rst = 0;
      #1;
      chk("ready_after_rst", 32'(in_ready), 32'h1);

      // R-type add x3,x1,x2
      step(1, 0, 0, 0, 3, 1, 2, 0, 0);
      idle();
      chk("rtype_we", 32'(imem_we), 32'h1);
      chk("rtype_addr", imem_addr, 32'h0);
      chk("rtype_word", imem_wdata, 32'h002081B3);
      chk("rtype_count", 32'(count), 32'h1);

      // I-type, SW, branch stream on consecutive cycles
      do_flush();
      base_i = log_data.size();
      step(1, 1, 0, 0, 5, 0, 0, 'hFFF, 0);
      step(1, 3, 0, 0, 0, 1, 2, 8, 0);
      step(1, 4, 0, 0, 0, 1, 2, 'hFFE, 0);
      idle(); idle();
      if (log_data.size() < base_i + 3) begin
         n_cmp++; n_bad++;
         $display("FAIL stream_len: got %0d, expected %0d", log_data.size() - base_i, 3);
      end else begin
         chk("stream_w0", log_data[base_i], 32'hFFF00293);
         chk("stream_w1", log_data[base_i+1], 32'h0020A423);
         chk("stream_w2", log_data[base_i+2], 32'hFE208EE3);
         chk("stream_a2", log_addr[base_i+2], 32'h8);
         chk("stream_gap", 32'(log_cyc[base_i+2] - log_cyc[base_i]), 32'h2);
      end

      // CTZ then an illegal class
      do_flush();
      step(1, 5, 0, 0, 4, 6, 0, 0, 0);
      step(1, 7, 0, 0, 1, 1, 1, 0, 0);
      chk("ctz_word", imem_wdata, 32'h0003024B);
      idle();
      chk("illegal_err", 32'(err), 32'h1);
      chk("illegal_count", 32'(count), 32'h1);
      chk("illegal_nowrite", 32'(imem_we), 32'h0);

      // Fill to DEPTH, fifth request held until flush
      do_flush();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, i + 1, 1, 2, 0, 0);
      step(1, 1, 0, 0, 9, 9, 0, 'h123, 0);
      chk("full_count", 32'(count), 32'h4);
      chk("full_ready", 32'(in_ready), 32'h0);
      step(1, 1, 0, 0, 9, 9, 0, 'h123, 1);
      idle();
      chk("flush_count", 32'(count), 32'h0);
      step(1, 1, 0, 0, 9, 9, 0, 'h123, 0);
      idle();
      chk("held_addr", imem_addr, BASE);
      chk("held_word", imem_wdata, 32'h12348493);

      // Reset in the cycle after acceptance
      step(1, 0, 0, 0, 7, 7, 7, 0, 0);
      @(posedge clk);
      rst = 1;
      exp_addr_q.delete(); exp_data_q.delete();
      m_count = 0; m_err = 0; in_valid = 0;
      #2;
      check_reset_vals();
      @(negedge clk);
      rst = 0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 4095), $urandom_range(0, 11) == 0);
      end
      idle(); idle();
      chk("drain", 32'(exp_data_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
